// File: rtl/axistream_pack_if.sv
// ---------------------------------------------------------------------------
// axistream_pack_if
// Bundles the narrow source stream and the wide destination stream of the
// axistream_pack width converter.
//   src_tvalid/src_tready/src_tdata/src_tlast   : narrow input beats
//   dest_tvalid/dest_tready/dest_tdata/dest_tkeep/dest_tlast : packed words
// Modports:
//   slave  : the packer (consumes src_*, produces dest_*)
//   master : the surrounding logic (produces src_*, consumes dest_*)
// ---------------------------------------------------------------------------
interface axistream_pack_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4
);
    logic                           src_tvalid;
    logic                           src_tready;
    logic [DATA_WIDTH-1:0]          src_tdata;
    logic                           src_tlast;

    logic                           dest_tvalid;
    logic                           dest_tready;
    logic [DATA_WIDTH*NUM_PACK-1:0] dest_tdata;
    logic [NUM_PACK-1:0]            dest_tkeep;
    logic                           dest_tlast;

    modport slave (
        input  src_tvalid, src_tdata, src_tlast, dest_tready,
        output src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
    );

    modport master (
        output src_tvalid, src_tdata, src_tlast, dest_tready,
        input  src_tready, dest_tvalid, dest_tdata, dest_tkeep, dest_tlast
    );
endinterface

// File: rtl/axistream_pack.sv
// ---------------------------------------------------------------------------
// axistream_pack
// Narrow-to-wide AXI-Stream converter: packs NUM_PACK consecutive DATA_WIDTH
// beats into one word. An early src_tlast closes a partial word; unfilled
// lanes are zero and cleared in dest_tkeep.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   axis  : axistream_pack_if.slave (src_* in, dest_* out)
// Parameters:
//   DATA_WIDTH : lane width
//   NUM_PACK   : lanes per output word (>= 1)
//   BIG_ENDIAN : 0 = first beat in lane 0, 1 = first beat in top lane
// ---------------------------------------------------------------------------
module axistream_pack #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_PACK   = 4,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    axistream_pack_if.slave   axis
);
    localparam int unsigned CNT_W  = (NUM_PACK > 1) ? $clog2(NUM_PACK) : 1;
    localparam int unsigned LANE_W = CNT_W;
    localparam int unsigned WORD_W = DATA_WIDTH * NUM_PACK;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PACK - 1);

    logic [WORD_W-1:0]   acc_data_q, acc_data_d;
    logic [NUM_PACK-1:0] acc_keep_q, acc_keep_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   out_data_q, out_data_d;
    logic [NUM_PACK-1:0] out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic                src_rdy;
    logic                accept;
    logic                complete;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   merged_data;
    logic [NUM_PACK-1:0] merged_keep;

    // Ready looks straight through to dest_tready so a draining word can be
    // replaced in the same cycle (back-to-back words without a bubble).
    assign src_rdy  = rst_n && (!out_valid_q || axis.dest_tready);
    assign accept   = axis.src_tvalid && src_rdy;
    assign complete = accept && ((cnt_q == CNT_MAX) || axis.src_tlast);
    assign lane     = BIG_ENDIAN ? (LANE_W'(NUM_PACK - 1) - cnt_q) : cnt_q;

    always_comb begin
        merged_data = acc_data_q;
        merged_keep = acc_keep_q;
        for (int unsigned l = 0; l < NUM_PACK; l++) begin
            if (LANE_W'(l) == lane) begin
                merged_data[l*DATA_WIDTH +: DATA_WIDTH] = axis.src_tdata;
                merged_keep[l] = 1'b1;
            end
        end
    end

    always_comb begin
        acc_data_d  = acc_data_q;
        acc_keep_d  = acc_keep_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        // Drain first; a completion below overrides it and keeps valid high.
        if (out_valid_q && axis.dest_tready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                out_data_d  = merged_data;
                out_keep_d  = merged_keep;
                out_last_d  = axis.src_tlast;
                out_valid_d = 1'b1;
                acc_data_d  = '0;
                acc_keep_d  = '0;
                cnt_d       = '0;
            end else begin
                acc_data_d  = merged_data;
                acc_keep_d  = merged_keep;
                cnt_d       = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_data_q  <= '0;
            acc_keep_q  <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_data_q  <= acc_data_d;
            acc_keep_q  <= acc_keep_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign axis.src_tready  = src_rdy;
    assign axis.dest_tvalid = out_valid_q;
    assign axis.dest_tdata  = out_data_q;
    assign axis.dest_tkeep  = out_keep_q;
    assign axis.dest_tlast  = out_last_q;
endmodule

// File: tb/tb_axistream_pack.sv
// ---------------------------------------------------------------------------
// tb_axistream_pack
// Drives a little-endian and a big-endian packer with identical stimulus and
// compares both against a packet-level model (beats collected in a queue,
// words built arithmetically when a packet or word closes).
// ---------------------------------------------------------------------------
module tb_axistream_pack;
    localparam int DW = 8;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axistream_pack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) if_le ();
    axistream_pack_if #(.DATA_WIDTH(DW), .NUM_PACK(NP)) if_be ();

    axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .axis(if_le));
    axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .axis(if_be));

    int tests = 0;
    int fails = 0;

    // model state
    logic [DW-1:0]      pkt[$];
    bit                 m_valid = 1'b0;
    logic [DW*NP-1:0]   m_le = '0, m_be = '0;
    logic [NP-1:0]      m_kl = '0, m_kb = '0;
    bit                 m_last = 1'b0;
    bit                 last_acc;
    int                 nb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
        if_le.src_tvalid = v; if_le.src_tdata = d; if_le.src_tlast = l; if_le.dest_tready = r;
        if_be.src_tvalid = v; if_be.src_tdata = d; if_be.src_tlast = l; if_be.dest_tready = r;
    endtask

    task automatic check_out();
        chk("tvalid_le", if_le.dest_tvalid, m_valid);
        chk("tvalid_be", if_be.dest_tvalid, m_valid);
        if (m_valid) begin
            chk("tdata_le", if_le.dest_tdata, m_le);
            chk("tkeep_le", if_le.dest_tkeep, m_kl);
            chk("tlast_le", if_le.dest_tlast, m_last);
            chk("tdata_be", if_be.dest_tdata, m_be);
            chk("tkeep_be", if_be.dest_tkeep, m_kb);
            chk("tlast_be", if_be.dest_tlast, m_last);
        end
    endtask

    // Called at a negedge: applies inputs, checks ready, advances the model
    // to the following edge and checks outputs at the next negedge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit r);
        bit exp_ready;
        drive(v, d, l, r);
        #1;
        exp_ready = !m_valid || r;
        chk("src_tready_le", if_le.src_tready, exp_ready);
        chk("src_tready_be", if_be.src_tready, exp_ready);
        last_acc = v && exp_ready;
        if (m_valid && r) m_valid = 1'b0;
        if (last_acc) begin
            pkt.push_back(d);
            if (pkt.size() == NP || l) begin
                m_le = '0; m_be = '0; m_kl = '0; m_kb = '0;
                for (int i = 0; i < pkt.size(); i++) begin
                    m_le = m_le | ((DW*NP)'(pkt[i]) << (DW*i));
                    m_be = m_be | ((DW*NP)'(pkt[i]) << (DW*(NP-1-i)));
                    m_kl[i] = 1'b1;
                    m_kb[NP-1-i] = 1'b1;
                end
                m_last = l;
                m_valid = 1'b1;
                pkt.delete();
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid_le", if_le.dest_tvalid, 1'b0);
        chk("rst_tvalid_be", if_be.dest_tvalid, 1'b0);
        chk("rst_tready_le", if_le.src_tready, 1'b0);
        chk("rst_tready_be", if_be.src_tready, 1'b0);
        chk("rst_tdata_le", if_le.dest_tdata, 32'h0);
        chk("rst_tkeep_le", if_le.dest_tkeep, 4'h0);
        #1;
        rst_n = 1'b1;
        pkt.delete();
        m_valid = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("init_tvalid", if_le.dest_tvalid, 1'b0);
        chk("init_tready", if_le.src_tready, 1'b0);
        chk("init_tkeep", if_be.dest_tkeep, 4'h0);
        chk("init_tlast", if_be.dest_tlast, 1'b0);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b1);

        // 1/2: full word, both endiannesses
        step(1'b1, 8'h11, 1'b0, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b1);
        step(1'b1, 8'h33, 1'b0, 1'b1);
        step(1'b1, 8'h44, 1'b1, 1'b1);
        chk("t1_model", m_le, 32'h44332211);
        chk("t1_le", if_le.dest_tdata, 32'h44332211);
        chk("t2_be", if_be.dest_tdata, 32'h11223344);
        chk("t1_keep", if_le.dest_tkeep, 4'b1111);
        chk("t1_last", if_le.dest_tlast, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // 3: early tlast, then a clean full word
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b1, 8'hBB, 1'b1, 1'b1);
        chk("t3_model_kb", m_kb, 4'b1100);
        chk("t3_le", if_le.dest_tdata, 32'h0000BBAA);
        chk("t3_keep_le", if_le.dest_tkeep, 4'b0011);
        chk("t3_be", if_be.dest_tdata, 32'hAABB0000);
        chk("t3_keep_be", if_be.dest_tkeep, 4'b1100);
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
        chk("t3_w2_le", if_le.dest_tdata, 32'h04030201);
        chk("t3_w2_keep", if_le.dest_tkeep, 4'b1111);
        chk("t3_w2_last", if_le.dest_tlast, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // 4: backpressure
        nb = 1;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 8'(nb), 1'b0, 1'b0);
            if (last_acc) nb++;
        end
        chk("t4_accepted", nb, 5);
        chk("t4_stall_rdy", if_le.src_tready, 1'b0);
        chk("t4_hold", if_le.dest_tdata, 32'h04030201);
        for (int c = 0; c < 4; c++) begin
            step(1'b1, 8'(nb), 1'b0, 1'b1);
            if (last_acc) nb++;
        end
        chk("t4_accepted2", nb, 9);
        chk("t4_w2", if_le.dest_tdata, 32'h08070605);
        step(1'b0, '0, 1'b0, 1'b1);

        // 5: reset mid-packet discards partial word
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        reset_pulse();
        step(1'b1, 8'h55, 1'b0, 1'b1);
        step(1'b1, 8'h66, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        step(1'b1, 8'h88, 1'b1, 1'b1);
        chk("t5_le", if_le.dest_tdata, 32'h88776655);
        chk("t5_be", if_be.dest_tdata, 32'h55667788);
        chk("t5_keep", if_le.dest_tkeep, 4'b1111);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t5_single", if_le.dest_tvalid, 1'b0);

        // 6: full rate
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b1);
            if (i == 3) chk("t6_w1", if_le.dest_tdata, 32'hA3A2A1A0);
            if (i == 4) chk("t6_gap", if_le.dest_tvalid, 1'b0);
            if (i == 7) chk("t6_w2", if_le.dest_tdata, 32'hA7A6A5A4);
        end
        step(1'b0, '0, 1'b0, 1'b1);

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0);
        end
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
